fb_loader: RTL
==============

# fb_loader

Frame-buffer writer for the VGA pipeline: accepts a row-major byte stream of a 320x240 image over a valid/ready interface and writes it into the write port of the dual-port pixel memory that the display side reads by pixel coordinate. The memory holds several image slots, and software selects the slot per frame. The loader owns the write port exclusively. The display read port is unaffected.

## Interface
- DATA_WIDTH, 8, pixel width in bits.
- ADDS_WIDTH, 18, memory address width.
- IMG_W, 320, image width in pixels.
- IMG_H, 240, image height in pixels.
- NUM_SLOTS, 3, number of image slots. Elaboration check: NUM_SLOTS*IMG_W*IMG_H <= 2^ADDS_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; arms a frame load into slot `slot`.
- slot  in  2  target slot index, sampled on start.
- abort  in  1  one-cycle pulse; returns the block to IDLE.
- s_data  in  DATA_WIDTH  pixel byte.
- s_valid  in  1  s_data valid.
- s_sof  in  1  start-of-frame marker; qualified by s_valid.
- s_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDS_WIDTH  write address.
- mem_wdata  out  DATA_WIDTH  write data.
- busy  out  1  high in ARMED or RECV.
- frame_done  out  1  one-cycle pulse; the full frame has been written.
- sof_err  out  1  one-cycle pulse; s_sof arrived mid-frame.
- slot_err  out  1  one-cycle pulse; start arrived with slot >= NUM_SLOTS.

## Operation
- A byte is accepted when s_valid && s_ready.
- s_ready is driven combinationally from state: 0 in IDLE, 1 in ARMED and RECV.
- **IDLE**
  - start with a valid slot: latch base = slot*IMG_W*IMG_H, selected from constants (no multiplier). Go to ARMED.
  - start with slot >= NUM_SLOTS: pulse slot_err and stay in IDLE.
- **ARMED**
  - Accepted bytes with s_sof=0 are discarded (no write).
  - An accepted byte with s_sof=1 is pixel (0,0). Write it at base, set x=1, y=0, go to RECV.
- **RECV**
  - Each accepted byte is written at the next linear address: address = base + y*IMG_W + x, maintained incrementally (+1 per pixel).
  - x wraps to 0 at IMG_W-1, and y then increments.
  - Accepted byte with s_sof=1: pulse sof_err, treat the byte as pixel (0,0) of a new frame at base, and stay in RECV.
  - Accepting pixel (IMG_W-1, IMG_H-1): write it, pulse frame_done, go to IDLE.
- **Start pulses**
  - start in ARMED or RECV is ignored; no slot change and no error.
  - start in the same cycle as the final pixel is ignored, because the state is still RECV.
- **abort**
  - From any state, go to IDLE next cycle. Counters are cleared.
  - A write already registered from the previous cycle still completes.
  - If abort coincides with an accepted byte, abort wins: the byte is not written.
  - If abort coincides with the final pixel, abort wins: no frame_done.
- **Counters**
  - x is $clog2(IMG_W) bits and y is $clog2(IMG_H) bits.
  - Address arithmetic is ADDS_WIDTH bits and never overflows, by the elaboration check.

## Timing
- Reset values: s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, frame_done=0, sof_err=0, slot_err=0. State resets to IDLE and base to 0.
- Write latency is 1 cycle: a byte accepted at edge N produces mem_we=1 with registered mem_addr/mem_wdata during cycle N+1.
- Throughput is one pixel per clock when s_valid is held high. A full frame takes 76800 accepted bytes.
- mem_we is high only in the cycle after an accepted, written byte. mem_addr/mem_wdata hold their last value when mem_we=0.
- frame_done is registered and aligned with mem_we of the final pixel. busy falls in that same cycle.
- sof_err is aligned with mem_we of the restarted pixel (0,0).
- slot_err is asserted in the cycle after the start pulse.
- start → ARMED takes 1 cycle, so s_ready=1 in the cycle after start.
- rst_n assertion mid-frame clears all outputs immediately, asynchronously. A partially written frame is left in memory.

## Structure
- Package fb_pkg holds:
  - IMG_W, IMG_H, NUM_SLOTS;
  - SLOT_SIZE = IMG_W*IMG_H;
  - the slot base constant array;
  - the state enum {IDLE, ARMED, RECV}.
- The display reader uses the same fb_pkg constants.
- One sub-module, fb_addr_gen, contains the x/y counters, last-pixel flag and linear address register. Its inputs are clear, load_base and step.
- The FSM, handshake and output registers live in fb_loader.

## Test plan
- Reset, then start with slot=1, then stream 76800 bytes (value = index mod 256) with s_sof on the first byte:
  - writes go to 76800..153599 with matching data;
  - frame_done pulses once, aligned with the addr 153599 write;
  - busy=0 afterwards.
- ARMED with 5 non-sof bytes, then a sof byte 0xAA: no writes for the first 5 bytes; the first write is addr=base, data=0xAA.
- Mid-frame s_sof at pixel index 1000 (slot 0): sof_err pulses, the next write goes to addr 0, and the frame completes 76800 bytes later.
- start with slot=3: slot_err pulses, state stays IDLE, and s_ready stays 0. A start during RECV is ignored, so the slot is unchanged.
- abort at pixel 500, including the same cycle as an accepted byte: that byte is not written, no frame_done, and IDLE follows. rst_n low mid-frame drops mem_we and busy to 0 immediately.
- Random s_valid gaps (50% duty): written addresses stay contiguous with no duplicates, and the data matches the stream order.

Source files
------------

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - frame-buffer geometry, slot map and loader state type
// Shared by the loader and the display reader so both agree on slot placement.
package fb_pkg;

  localparam int IMG_W     = 320;
  localparam int IMG_H     = 240;
  localparam int NUM_SLOTS = 3;
  localparam int SLOT_SIZE = IMG_W * IMG_H;

  localparam int SLOT_BASE [4] = '{0, SLOT_SIZE, 2 * SLOT_SIZE, 3 * SLOT_SIZE};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RECV  = 2'd2
  } state_t;

  // Slot base as a sum of the slot size, so callers never need a multiplier.
  function automatic int slot_base(input int slot_idx, input int slot_size);
    case (slot_idx)
      0:       return 0;
      1:       return slot_size;
      2:       return slot_size + slot_size;
      default: return slot_size + slot_size + slot_size;
    endcase
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// rtl/fb_addr_gen.sv - pixel x/y counters and incremental linear write address
// load_base marks the accepted byte as pixel (0,0); step marks any later pixel.
module fb_addr_gen #(
  parameter int ADDS_WIDTH = 18,
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 240
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  load_base_i,
  input  logic                  step_i,
  input  logic [ADDS_WIDTH-1:0] base_i,
  output logic [ADDS_WIDTH-1:0] pix_addr_o,
  output logic                  last_o
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [ADDS_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (clear_i) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (load_base_i) begin
      x_d    = XW'(1);
      y_d    = '0;
      addr_d = base_i + ADDS_WIDTH'(1);
    end else if (step_i) begin
      addr_d = addr_q + ADDS_WIDTH'(1);
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  // A restarting pixel goes to the slot base rather than the running address.
  assign pix_addr_o = load_base_i ? base_i : addr_q;
  assign last_o     = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/fb_loader.sv
// rtl/fb_loader.sv - streams a row-major image into one slot of the pixel memory
// Owns the memory write port; one registered write per accepted pixel.
module fb_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDS_WIDTH = 18,
  parameter int IMG_W      = fb_pkg::IMG_W,
  parameter int IMG_H      = fb_pkg::IMG_H,
  parameter int NUM_SLOTS  = fb_pkg::NUM_SLOTS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            slot,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_sof,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [ADDS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  sof_err,
  output logic                  slot_err
);

  import fb_pkg::*;

  localparam int SLOT_SZ = IMG_W * IMG_H;

  if (NUM_SLOTS * SLOT_SZ > (1 << ADDS_WIDTH)) begin : g_size_check
    $error("fb_loader: image slots exceed the memory address space");
  end
  if (NUM_SLOTS > 4) begin : g_slot_check
    $error("fb_loader: slot index is only two bits wide");
  end

  localparam logic [ADDS_WIDTH-1:0] BASE_LUT [4] = '{
    ADDS_WIDTH'(slot_base(0, SLOT_SZ)),
    ADDS_WIDTH'(slot_base(1, SLOT_SZ)),
    ADDS_WIDTH'(slot_base(2, SLOT_SZ)),
    ADDS_WIDTH'(slot_base(3, SLOT_SZ))
  };

  state_t                  state_q, state_d;
  logic [ADDS_WIDTH-1:0]   base_q;
  logic                    mem_we_q, frame_done_q, sof_err_q, slot_err_q;
  logic [ADDS_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;

  logic                    slot_ok, start_ok, accept;
  logic                    wr_en, ag_clear, ag_load, ag_step;
  logic                    frame_done_d, sof_err_d, slot_err_d;
  logic                    is_last;
  logic [ADDS_WIDTH-1:0]   pix_addr;

  assign slot_ok  = int'(slot) < NUM_SLOTS;
  assign start_ok = (state_q == IDLE) && start && !abort && slot_ok;
  assign accept   = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_ok)                        state_d = ARMED;
        ARMED:   if (accept && s_sof)                 state_d = RECV;
        RECV:    if (accept && !s_sof && is_last)     state_d = IDLE;
        default:                                      state_d = IDLE;
      endcase
    end
  end

  // Abort outranks everything, including a byte accepted in the same cycle.
  always_comb begin
    s_ready      = (state_q == ARMED) || (state_q == RECV);
    busy         = (state_q == ARMED) || (state_q == RECV);
    wr_en        = accept && !abort && ((state_q == RECV) || s_sof);
    ag_load      = wr_en && s_sof;
    ag_step      = wr_en && !s_sof;
    ag_clear     = abort || start_ok;
    frame_done_d = ag_step && is_last;
    sof_err_d    = ag_load && (state_q == RECV);
    slot_err_d   = (state_q == IDLE) && start && !abort && !slot_ok;
  end

  fb_addr_gen #(
    .ADDS_WIDTH (ADDS_WIDTH),
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (ag_clear),
    .load_base_i (ag_load),
    .step_i      (ag_step),
    .base_i      (base_q),
    .pix_addr_o  (pix_addr),
    .last_o      (is_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q       <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
      slot_err_q   <= 1'b0;
    end else begin
      if (start_ok) base_q <= BASE_LUT[slot];
      mem_we_q     <= wr_en;
      if (wr_en) begin
        mem_addr_q  <= pix_addr;
        mem_wdata_q <= s_data;
      end
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
      slot_err_q   <= slot_err_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign frame_done = frame_done_q;
  assign sof_err    = sof_err_q;
  assign slot_err   = slot_err_q;

endmodule
